sonar_rx_quadro: RTL and testbench
==================================

// Module: sonar_rx_quadro
// PURPOSE
//  Host-side receiver for the sonar serial link. Deserialises the 8N1 ASCII stream
//  emitted by the sonar controller and parses the frame "AAA,DDD#": 3 angle digits,
//  comma, 3 distance digits, '#'. Publishes angle/distance as packed BCD with a
//  one-cycle valid pulse. Sits between the rx pin and the display/plot logic.
// PARAMETERS
//  BIT_CYCLES  434  clock cycles per serial bit (50 MHz / 115200); must be >= 4
// PORTS
//  clock       in   1   system clock, rising edge
//  reset       in   1   asynchronous, active-high
//  rx          in   1   serial input, idle high, asynchronous to clock
//  angulo      out  12  angle BCD {hundreds, tens, units}
//  distancia   out  12  distance BCD {hundreds, tens, units}
//  quadro_ok   out  1   1-cycle pulse: new frame committed to angulo/distancia
//  quadro_erro out  1   1-cycle pulse: malformed byte or framing error
//  db_estado   out  4   parser state code for debug displays
// BEHAVIOUR
//  Reset: angulo=0, distancia=0, quadro_ok=0, quadro_erro=0, rx FSM IDLE, parser ANG0.
//  rx passes through a 2-FF synchroniser; all decisions use the synchronised value.
//  Rx FSM: IDLE -> START on synced rx=0. START: wait BIT_CYCLES/2 (integer div);
//   if rx still 0 -> DATA, else back to IDLE (glitch, nothing reported).
//   DATA: sample every BIT_CYCLES, 8 bits, LSB first. STOP: sample after BIT_CYCLES;
//   rx=1 -> byte_ok internal pulse; rx=0 -> byte_err internal pulse. Both -> IDLE.
//   A start bit directly after the stop sample is accepted (no idle gap required).
//  Parser acts in the cycle after byte_ok/byte_err; outputs are registered.
//  Digit = byte in 0x30..0x39; nibble stored = byte[3:0] into shadow regs.
//  States/codes: ANG0 0, ANG1 1, ANG2 2, VIRG 3, DIST0 4, DIST1 5, DIST2 6, FIM 7, SYNC 8.
//   ANGx/DISTx: digit -> next state; VIRG: ',' -> DIST0; FIM: '#' -> ANG0.
//   FIM accepting '#': angulo<=shadow angle, distancia<=shadow distance, quadro_ok=1
//   for exactly one cycle, same edge.
//   Any unexpected byte, or byte_err, in ANG0..FIM: quadro_erro=1 one cycle,
//   go SYNC; angulo/distancia keep previous values.
//   SYNC: discard bytes until '#' (no pulse), then ANG0. byte_err in SYNC: stay, no pulse.
//  quadro_ok and quadro_erro are never high together.
//  Reset mid-byte or mid-frame: all partial data discarded, reset values restored.
// TESTING (bench uses BIT_CYCLES=8)
//  1 "045,123#" -> angulo=12'h045, distancia=12'h123, one quadro_ok pulse, no erro.
//  2 "04X,..." then "090,200#" -> erro pulse at 'X', SYNC until '#', outputs hold 045/123
//    from prior frame; "090,200#" -> angulo=12'h090, distancia=12'h200, quadro_ok.
//  3 rx low for 2 cycles then high -> no byte, db_estado unchanged, no pulses.
//  4 byte '1' sent with stop bit=0 in ANG1 -> quadro_erro pulse, db_estado=8.
//  5 reset asserted during 5th data bit of a frame -> outputs 0, db_estado=0;
//    next "180,007#" decodes to 12'h180/12'h007.
//  6 two frames back-to-back, zero idle bits -> two quadro_ok pulses, final values match 2nd.

Source files
------------

// File: rtl/sonar_rx_quadro_if.sv
// ---------------------------------------------------------------------------
// sonar_rx_quadro_if
// Bundles the serial line and the decoded-frame outputs of the sonar receiver.
//   rx          serial input, idle high, asynchronous to the receiver clock
//   angulo      angle, packed BCD {hundreds, tens, units}
//   distancia   distance, packed BCD {hundreds, tens, units}
//   quadro_ok   one-cycle pulse: a new frame was committed
//   quadro_erro one-cycle pulse: malformed byte or framing error
//   db_estado   parser state code for debug displays
// Modports:
//   master  the side that drives the line and consumes the frames (host / bench)
//   slave   the receiver itself
// ---------------------------------------------------------------------------
interface sonar_rx_quadro_if;
  logic        rx;
  logic [11:0] angulo;
  logic [11:0] distancia;
  logic        quadro_ok;
  logic        quadro_erro;
  logic [3:0]  db_estado;

  modport master (
    output rx,
    input  angulo, distancia, quadro_ok, quadro_erro, db_estado
  );

  modport slave (
    input  rx,
    output angulo, distancia, quadro_ok, quadro_erro, db_estado
  );
endinterface

// File: rtl/sonar_rx_quadro.sv
// ---------------------------------------------------------------------------
// sonar_rx_quadro
// Host-side receiver for the sonar serial link. Deserialises the 8N1 ASCII
// stream from the sonar controller and parses frames of the form "AAA,DDD#"
// (3 angle digits, comma, 3 distance digits, '#'). The decoded values are
// published as packed BCD together with a one-cycle valid pulse.
//
// Parameters:
//   BIT_CYCLES  clock cycles per serial bit (>= 4)
// Ports:
//   clock  system clock, rising edge
//   reset  asynchronous, active-high
//   bus    sonar_rx_quadro_if.slave: rx in; angulo, distancia, quadro_ok,
//          quadro_erro, db_estado out
// ---------------------------------------------------------------------------
module sonar_rx_quadro #(
  parameter int BIT_CYCLES = 434
) (
  input  logic                   clock,
  input  logic                   reset,
  sonar_rx_quadro_if.slave       bus
);

  localparam int              CW      = $clog2(BIT_CYCLES);
  localparam logic [CW-1:0]   FULL_M1 = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0]   HALF_M1 = CW'(BIT_CYCLES / 2 - 1);

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  typedef enum logic [3:0] {
    P_ANG0  = 4'd0,
    P_ANG1  = 4'd1,
    P_ANG2  = 4'd2,
    P_VIRG  = 4'd3,
    P_DIST0 = 4'd4,
    P_DIST1 = 4'd5,
    P_DIST2 = 4'd6,
    P_FIM   = 4'd7,
    P_SYNC  = 4'd8
  } p_state_t;

  localparam logic [7:0] CH_COMMA = 8'h2C;
  localparam logic [7:0] CH_HASH  = 8'h23;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= 8'h30) && (b <= 8'h39);
  endfunction

  // -------------------------------------------------------------------------
  // Input synchroniser. Idle level is high so reset must not look like a
  // start bit.
  // -------------------------------------------------------------------------
  logic rx_meta_q, rx_sync_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours, as real flops do.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= bus.rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  // -------------------------------------------------------------------------
  // Byte receiver. START waits half a bit to land on the bit centre, then
  // DATA/STOP sample once per bit period from there.
  // -------------------------------------------------------------------------
  rx_state_t       rx_state_q, rx_state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            byte_ok_q, byte_ok_d;
  logic            byte_err_q, byte_err_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_state_q <= RX_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      byte_ok_q  <= 1'b0;
      byte_err_q <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      byte_ok_q  <= byte_ok_d;
      byte_err_q <= byte_err_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    rx_state_d = rx_state_q;
    cnt_d      = cnt_q + 1'b1;
    bit_d      = bit_q;
    shift_d    = shift_q;
    byte_ok_d  = 1'b0;
    byte_err_d = 1'b0;

    unique case (rx_state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (!rx_sync_q) rx_state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          bit_d = '0;
          // A start bit that vanished before its centre is a glitch.
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {rx_sync_q, shift_q[7:1]};  // LSB arrives first
          if (bit_q == 3'd7) rx_state_d = RX_STOP;
          else               bit_d      = bit_q + 3'd1;
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d      = '0;
          byte_ok_d  = rx_sync_q;
          byte_err_d = !rx_sync_q;
          // IDLE checks rx on the very next cycle, so a start bit may follow
          // the stop bit with no idle gap.
          rx_state_d = RX_IDLE;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Frame parser. Digits collect into shadow registers and are only copied to
  // the visible outputs when the terminating '#' arrives, so a broken frame
  // never disturbs the last good values. shift_q is stable here because the
  // next byte cannot shift in its first bit for another half bit period.
  // -------------------------------------------------------------------------
  p_state_t    p_state_q, p_state_d;
  logic [11:0] sh_ang_q, sh_ang_d;
  logic [11:0] sh_dist_q, sh_dist_d;
  logic [11:0] angulo_q, angulo_d;
  logic [11:0] dist_q, dist_d;
  logic        ok_q, ok_d;
  logic        erro_q, erro_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      p_state_q <= P_ANG0;
      sh_ang_q  <= '0;
      sh_dist_q <= '0;
      angulo_q  <= '0;
      dist_q    <= '0;
      ok_q      <= 1'b0;
      erro_q    <= 1'b0;
    end else begin
      p_state_q <= p_state_d;
      sh_ang_q  <= sh_ang_d;
      sh_dist_q <= sh_dist_d;
      angulo_q  <= angulo_d;
      dist_q    <= dist_d;
      ok_q      <= ok_d;
      erro_q    <= erro_d;
    end
  end

  always_comb begin
    p_state_d = p_state_q;
    sh_ang_d  = sh_ang_q;
    sh_dist_d = sh_dist_q;
    angulo_d  = angulo_q;
    dist_d    = dist_q;
    ok_d      = 1'b0;
    erro_d    = 1'b0;

    if (p_state_q == P_SYNC) begin
      // Resynchronise silently on the next good '#'.
      if (byte_ok_q && shift_q == CH_HASH) p_state_d = P_ANG0;
    end else if (byte_err_q) begin
      erro_d    = 1'b1;
      p_state_d = P_SYNC;
    end else if (byte_ok_q) begin
      // Assume the byte is bad; each accepting branch clears that.
      erro_d    = 1'b1;
      p_state_d = P_SYNC;
      unique case (p_state_q)
        P_ANG0: if (is_digit(shift_q)) begin
          sh_ang_d[11:8] = shift_q[3:0];
          erro_d = 1'b0; p_state_d = P_ANG1;
        end
        P_ANG1: if (is_digit(shift_q)) begin
          sh_ang_d[7:4] = shift_q[3:0];
          erro_d = 1'b0; p_state_d = P_ANG2;
        end
        P_ANG2: if (is_digit(shift_q)) begin
          sh_ang_d[3:0] = shift_q[3:0];
          erro_d = 1'b0; p_state_d = P_VIRG;
        end
        P_VIRG: if (shift_q == CH_COMMA) begin
          erro_d = 1'b0; p_state_d = P_DIST0;
        end
        P_DIST0: if (is_digit(shift_q)) begin
          sh_dist_d[11:8] = shift_q[3:0];
          erro_d = 1'b0; p_state_d = P_DIST1;
        end
        P_DIST1: if (is_digit(shift_q)) begin
          sh_dist_d[7:4] = shift_q[3:0];
          erro_d = 1'b0; p_state_d = P_DIST2;
        end
        P_DIST2: if (is_digit(shift_q)) begin
          sh_dist_d[3:0] = shift_q[3:0];
          erro_d = 1'b0; p_state_d = P_FIM;
        end
        P_FIM: if (shift_q == CH_HASH) begin
          angulo_d = sh_ang_q;
          dist_d   = sh_dist_q;
          ok_d     = 1'b1;
          erro_d   = 1'b0; p_state_d = P_ANG0;
        end
        default: ;
      endcase
    end
  end

  assign bus.angulo      = angulo_q;
  assign bus.distancia   = dist_q;
  assign bus.quadro_ok   = ok_q;
  assign bus.quadro_erro = erro_q;
  assign bus.db_estado   = p_state_q;

endmodule

// File: tb/tb_sonar_rx_quadro.sv
// ---------------------------------------------------------------------------
// tb_sonar_rx_quadro
// Directed bench for sonar_rx_quadro with BIT_CYCLES = 8. Serial bytes are
// driven on the falling edge; outputs are sampled on the falling edge.
// A background monitor counts quadro_ok / quadro_erro cycles so each test can
// check exact pulse counts.
// ---------------------------------------------------------------------------
module tb_sonar_rx_quadro;

  localparam int BIT = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;

  sonar_rx_quadro_if bus ();

  sonar_rx_quadro #(.BIT_CYCLES(BIT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Pulse monitor: counts every high cycle, so a stuck pulse shows as > 1.
  int ok_cnt   = 0;
  int erro_cnt = 0;
  int both_cnt = 0;

  always @(negedge clock) begin
    if (!reset) begin
      if (bus.quadro_ok)                    ok_cnt++;
      if (bus.quadro_erro)                  erro_cnt++;
      if (bus.quadro_ok && bus.quadro_erro) both_cnt++;
    end
  end

  task automatic idle(input int cycles);
    bus.rx = 1'b1;
    repeat (cycles) @(negedge clock);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    bus.rx = 1'b0;
    repeat (BIT) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      bus.rx = b[i];
      repeat (BIT) @(negedge clock);
    end
    bus.rx = stop;
    repeat (BIT) @(negedge clock);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset();
    bus.rx = 1'b1;
    reset  = 1'b1;
    repeat (3) @(negedge clock);
    n_checks++;
    if (bus.angulo !== 12'h000) begin
      n_fail++; $display("FAIL reset_angulo got=%h exp=%h", bus.angulo, 12'h000);
    end
    n_checks++;
    if (bus.distancia !== 12'h000) begin
      n_fail++; $display("FAIL reset_distancia got=%h exp=%h", bus.distancia, 12'h000);
    end
    n_checks++;
    if ({bus.quadro_ok, bus.quadro_erro} !== 2'b00) begin
      n_fail++; $display("FAIL reset_pulses got=%b exp=00", {bus.quadro_ok, bus.quadro_erro});
    end
    n_checks++;
    if (bus.db_estado !== 4'd0) begin
      n_fail++; $display("FAIL reset_estado got=%0d exp=0", bus.db_estado);
    end
    reset = 1'b0;
    idle(5);
  endtask

  task automatic test_frame();
    int ok0, er0;
    ok0 = ok_cnt; er0 = erro_cnt;
    send_str("045,123#");
    idle(4);
    n_checks++;
    if (bus.angulo !== 12'h045) begin
      n_fail++; $display("FAIL frame_angulo got=%h exp=%h", bus.angulo, 12'h045);
    end
    n_checks++;
    if (bus.distancia !== 12'h123) begin
      n_fail++; $display("FAIL frame_distancia got=%h exp=%h", bus.distancia, 12'h123);
    end
    n_checks++;
    if (ok_cnt - ok0 !== 1) begin
      n_fail++; $display("FAIL frame_ok_pulses got=%0d exp=1", ok_cnt - ok0);
    end
    n_checks++;
    if (erro_cnt - er0 !== 0) begin
      n_fail++; $display("FAIL frame_erro_pulses got=%0d exp=0", erro_cnt - er0);
    end
    n_checks++;
    if (bus.db_estado !== 4'd0) begin
      n_fail++; $display("FAIL frame_estado got=%0d exp=0", bus.db_estado);
    end
  endtask

  task automatic test_bad_byte();
    int ok0, er0;
    ok0 = ok_cnt; er0 = erro_cnt;
    send_str("04X");
    idle(4);
    n_checks++;
    if (erro_cnt - er0 !== 1) begin
      n_fail++; $display("FAIL bad_erro_pulses got=%0d exp=1", erro_cnt - er0);
    end
    n_checks++;
    if (bus.db_estado !== 4'd8) begin
      n_fail++; $display("FAIL bad_estado got=%0d exp=8", bus.db_estado);
    end
    n_checks++;
    if ({bus.angulo, bus.distancia} !== {12'h045, 12'h123}) begin
      n_fail++; $display("FAIL bad_hold got=%h/%h exp=045/123", bus.angulo, bus.distancia);
    end
    // Bytes while in SYNC are discarded; '#' returns to ANG0 with no pulse.
    send_str(",5#");
    idle(4);
    n_checks++;
    if (bus.db_estado !== 4'd0) begin
      n_fail++; $display("FAIL resync_estado got=%0d exp=0", bus.db_estado);
    end
    n_checks++;
    if ((ok_cnt - ok0 !== 0) || (erro_cnt - er0 !== 1)) begin
      n_fail++; $display("FAIL resync_pulses got ok=%0d erro=%0d exp ok=0 erro=1",
                         ok_cnt - ok0, erro_cnt - er0);
    end
    send_str("090,200#");
    idle(4);
    n_checks++;
    if ({bus.angulo, bus.distancia} !== {12'h090, 12'h200}) begin
      n_fail++; $display("FAIL resync_frame got=%h/%h exp=090/200", bus.angulo, bus.distancia);
    end
    n_checks++;
    if (ok_cnt - ok0 !== 1) begin
      n_fail++; $display("FAIL resync_ok_pulses got=%0d exp=1", ok_cnt - ok0);
    end
  endtask

  task automatic test_glitch();
    int ok0, er0;
    logic [3:0] st0;
    ok0 = ok_cnt; er0 = erro_cnt; st0 = bus.db_estado;
    bus.rx = 1'b0;
    repeat (2) @(negedge clock);
    idle(30);
    n_checks++;
    if (bus.db_estado !== st0) begin
      n_fail++; $display("FAIL glitch_estado got=%0d exp=%0d", bus.db_estado, st0);
    end
    n_checks++;
    if ((ok_cnt - ok0 !== 0) || (erro_cnt - er0 !== 0)) begin
      n_fail++; $display("FAIL glitch_pulses got ok=%0d erro=%0d exp 0/0",
                         ok_cnt - ok0, erro_cnt - er0);
    end
  endtask

  task automatic test_stop_error();
    int ok0, er0;
    ok0 = ok_cnt; er0 = erro_cnt;
    send_str("0");             // ANG0 -> ANG1
    n_checks++;
    if (bus.db_estado !== 4'd1) begin
      n_fail++; $display("FAIL stop_pre_estado got=%0d exp=1", bus.db_estado);
    end
    send_byte("1", 1'b0);      // framing error
    idle(120);
    n_checks++;
    if (erro_cnt - er0 !== 1) begin
      n_fail++; $display("FAIL stop_erro_pulses got=%0d exp=1", erro_cnt - er0);
    end
    n_checks++;
    if (bus.db_estado !== 4'd8) begin
      n_fail++; $display("FAIL stop_estado got=%0d exp=8", bus.db_estado);
    end
    n_checks++;
    if (ok_cnt - ok0 !== 0) begin
      n_fail++; $display("FAIL stop_ok_pulses got=%0d exp=0", ok_cnt - ok0);
    end
    send_str("#");
    idle(4);
  endtask

  task automatic test_reset_mid_byte();
    logic [7:0] b;
    send_str("12");            // parser now in ANG2, outputs still 090/200
    b = "3";
    bus.rx = 1'b0;
    repeat (BIT) @(negedge clock);
    for (int i = 0; i < 4; i++) begin
      bus.rx = b[i];
      repeat (BIT) @(negedge clock);
    end
    bus.rx = b[4];
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    n_checks++;
    if ({bus.angulo, bus.distancia} !== 24'h000000) begin
      n_fail++; $display("FAIL midrst_outputs got=%h/%h exp=000/000", bus.angulo, bus.distancia);
    end
    n_checks++;
    if (bus.db_estado !== 4'd0) begin
      n_fail++; $display("FAIL midrst_estado got=%0d exp=0", bus.db_estado);
    end
    bus.rx = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    idle(10);
    send_str("180,007#");
    idle(4);
    n_checks++;
    if ({bus.angulo, bus.distancia} !== {12'h180, 12'h007}) begin
      n_fail++; $display("FAIL midrst_frame got=%h/%h exp=180/007", bus.angulo, bus.distancia);
    end
  endtask

  task automatic test_back_to_back();
    int ok0, er0;
    ok0 = ok_cnt; er0 = erro_cnt;
    send_str("111,222#333,444#");
    idle(4);
    n_checks++;
    if (ok_cnt - ok0 !== 2) begin
      n_fail++; $display("FAIL b2b_ok_pulses got=%0d exp=2", ok_cnt - ok0);
    end
    n_checks++;
    if (erro_cnt - er0 !== 0) begin
      n_fail++; $display("FAIL b2b_erro_pulses got=%0d exp=0", erro_cnt - er0);
    end
    n_checks++;
    if ({bus.angulo, bus.distancia} !== {12'h333, 12'h444}) begin
      n_fail++; $display("FAIL b2b_frame got=%h/%h exp=333/444", bus.angulo, bus.distancia);
    end
  endtask

  task automatic test_exclusive();
    n_checks++;
    if (both_cnt !== 0) begin
      n_fail++; $display("FAIL ok_erro_overlap got=%0d exp=0", both_cnt);
    end
  endtask

  initial begin
    bus.rx = 1'b1;
    test_reset();
    test_frame();
    test_bad_byte();
    test_glitch();
    test_stop_error();
    test_reset_mid_byte();
    test_back_to_back();
    test_exclusive();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
